// File: rtl/cursor_grid.sv
// cursor_grid: cursor position keeper and row-scanned one-hot LED matrix driver.
// Direction pulses L/R/U/D move the cursor; opposing pulses in one cycle cancel.
// Compile-time option: define CURSOR_WRAP_EN to wrap at the matrix edges;
// leave it undefined to clamp at the edges instead.
module cursor_grid #(
   parameter int WIDTH    = 8,
   parameter int HEIGHT   = 8,
   parameter int SCAN_DIV = 4,
   parameter int X0       = 0,
   parameter int Y0       = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      L,
   input  logic                      R,
   input  logic                      U,
   input  logic                      D,
   output logic [$clog2(WIDTH)-1:0]  x,
   output logic [$clog2(HEIGHT)-1:0] y,
   output logic                      moved,
   output logic [HEIGHT-1:0]         row_sel,
   output logic [WIDTH-1:0]          col_on
);

   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [XW-1:0]     X_ONE    = XW'(1);
   localparam logic [XW-1:0]     X_MAX    = XW'(WIDTH - 1);
   localparam logic [XW-1:0]     X_RST    = XW'(X0);
   localparam logic [YW-1:0]     Y_ONE    = YW'(1);
   localparam logic [YW-1:0]     Y_MAX    = YW'(HEIGHT - 1);
   localparam logic [YW-1:0]     Y_RST    = YW'(Y0);
   localparam logic [DW-1:0]     DIV_ONE  = DW'(1);
   localparam logic [DW-1:0]     DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [HEIGHT-1:0] ROW_ONE  = HEIGHT'(1);
   localparam logic [WIDTH-1:0]  COL_ONE  = WIDTH'(1);

   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic              r_moved;
   logic [DW-1:0]     r_div;
   logic [YW-1:0]     r_row;
   logic [HEIGHT-1:0] r_row_sel;
   logic [WIDTH-1:0]  r_col_on;

   logic              w_inc_x;
   logic              w_dec_x;
   logic              w_inc_y;
   logic              w_dec_y;
   logic [XW-1:0]     w_x_nxt;
   logic [YW-1:0]     w_y_nxt;
   logic              w_moved_nxt;
   logic              w_div_tc;
   logic [DW-1:0]     w_div_nxt;
   logic [YW-1:0]     w_row_nxt;
   logic [HEIGHT-1:0] w_row_sel_nxt;
   logic [WIDTH-1:0]  w_col_on_nxt;

   // Decode the enabled, non-cancelling step directions.
   always_comb begin
      w_inc_x = en & R & ~L;
      w_dec_x = en & L & ~R;
      w_inc_y = en & D & ~U;
      w_dec_y = en & U & ~D;
   end

   // Next cursor position with edge handling; moved only on a real change.
   always_comb begin
      w_x_nxt = r_x;
      w_y_nxt = r_y;
`ifdef CURSOR_WRAP_EN
      if (w_inc_x)      w_x_nxt = r_x + X_ONE;
      else if (w_dec_x) w_x_nxt = r_x - X_ONE;
      else              w_x_nxt = r_x;
      if (w_inc_y)      w_y_nxt = r_y + Y_ONE;
      else if (w_dec_y) w_y_nxt = r_y - Y_ONE;
      else              w_y_nxt = r_y;
`else
      if (w_inc_x && (r_x != X_MAX))                 w_x_nxt = r_x + X_ONE;
      else if (w_dec_x && (r_x != {XW{1'b0}}))       w_x_nxt = r_x - X_ONE;
      else                                           w_x_nxt = r_x;
      if (w_inc_y && (r_y != Y_MAX))                 w_y_nxt = r_y + Y_ONE;
      else if (w_dec_y && (r_y != {YW{1'b0}}))       w_y_nxt = r_y - Y_ONE;
      else                                           w_y_nxt = r_y;
`endif
      w_moved_nxt = (w_x_nxt != r_x) || (w_y_nxt != r_y);
   end

   // Free-running row dwell divider and row index, plus the scan drive decode.
   always_comb begin
      w_div_tc  = (r_div == DIV_LAST);
      w_div_nxt = r_div;
      w_row_nxt = r_row;
      if (w_div_tc) begin
         w_div_nxt = {DW{1'b0}};
         if (r_row == Y_MAX) w_row_nxt = {YW{1'b0}};
         else                w_row_nxt = r_row + Y_ONE;
      end else begin
         w_div_nxt = r_div + DIV_ONE;
         w_row_nxt = r_row;
      end
      w_row_sel_nxt = ROW_ONE << r_row;
      if (r_row == r_y) w_col_on_nxt = COL_ONE << r_x;
      else              w_col_on_nxt = {WIDTH{1'b0}};
   end

   // Cursor state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_x     <= X_RST;
         r_y     <= Y_RST;
         r_moved <= 1'b0;
      end else begin
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         r_moved <= w_moved_nxt;
      end
   end

   // Scan state and registered matrix drive (reflects previous-cycle row and cursor).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div     <= {DW{1'b0}};
         r_row     <= {YW{1'b0}};
         r_row_sel <= {HEIGHT{1'b0}};
         r_col_on  <= {WIDTH{1'b0}};
      end else begin
         r_div     <= w_div_nxt;
         r_row     <= w_row_nxt;
         r_row_sel <= w_row_sel_nxt;
         r_col_on  <= w_col_on_nxt;
      end
   end

   assign x       = r_x;
   assign y       = r_y;
   assign moved   = r_moved;
   assign row_sel = r_row_sel;
   assign col_on  = r_col_on;

endmodule
